// File: rtl/doraemon_tx_if.sv
// Consumer-side link of the doraemon record interface.
// master (doraemon_tx): drives in_valid and the record fields, and receives
//   ready plus the out_valid/out result strobe.
// slave (CDC consumer): the mirror image of master.
interface doraemon_tx_if;
    logic       ready;
    logic       in_valid;
    logic [4:0] doraemon_id;
    logic [7:0] size;
    logic [7:0] iq_score;
    logic [7:0] eq_score;
    logic [2:0] size_weight;
    logic [2:0] iq_weight;
    logic [2:0] eq_weight;
    logic       out_valid;
    logic [7:0] out;

    modport master (
        input  ready, out_valid, out,
        output in_valid, doraemon_id, size, iq_score, eq_score,
               size_weight, iq_weight, eq_weight
    );

    modport slave (
        output ready, out_valid, out,
        input  in_valid, doraemon_id, size, iq_score, eq_score,
               size_weight, iq_weight, eq_weight
    );
endinterface

// File: rtl/doraemon_tx.sv
// doraemon_tx: transmit side of the doraemon record interface (clk1 domain).
// Host pushes 38-bit records into a small FIFO. One record is issued per
// one-cycle in_valid pulse while the consumer is ready. Consumer results are
// counted against issued records.
// Ports:
//   clk1, rst_n          clock, synchronous active-low reset
//   push, push_data      host write port {id,size,iq,eq,size_w,iq_w,eq_w}
//   full, empty          FIFO state after the last edge
//   overflow             sticky, set when a push is refused
//   cif (master)         ready/in_valid/record fields/out_valid/out
//   rsp_valid, rsp_data  out_valid/out delayed by one cycle
//   outstanding          issued minus answered records
//   resp_err             sticky, set when a result arrives with nothing outstanding
module doraemon_tx #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned GAP       = 1,
    parameter int unsigned MAX_OUTST = 8
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        push,
    input  logic [37:0] push_data,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    doraemon_tx_if.master cif,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [3:0]  outstanding,
    output logic        resp_err
);
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam int unsigned RW       = 38;
    localparam logic [2:0]  GAP_LAST = 3'((GAP == 0) ? 0 : GAP - 1);
    localparam logic [4:0]  MAX_O    = 5'(MAX_OUTST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    gap_cnt_q, gap_cnt_d;
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          in_valid_q, in_valid_d;
    logic [RW-1:0] rec_q, rec_d;
    logic [3:0]    outst_q, outst_d;
    logic          resp_err_q, resp_err_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;

    logic [RW-1:0] mem [DEPTH];

    logic          issue_slot;
    logic          issue;
    logic          push_ok;
    logic          send_now;
    logic [4:0]    outst_eff;

    // Next-state, FIFO pointer, counter and output computation.
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        outst_d     = outst_q;
        resp_err_d  = resp_err_q;
        in_valid_d  = 1'b0;
        rec_d       = '0;
        rsp_valid_d = cif.out_valid;
        rsp_data_d  = cif.out_valid ? cif.out : 8'd0;

        send_now = (state_q == S_SEND);

        // The issue decision is taken in the cycle just before the next pulse
        // may appear: any IDLE cycle, the last GAP cycle, or the SEND cycle
        // itself when no gap is configured. This yields exactly GAP idle
        // cycles between consecutive pulses.
        case (state_q)
            S_IDLE:  issue_slot = 1'b1;
            S_SEND:  issue_slot = (GAP == 0);
            S_GAP:   issue_slot = (gap_cnt_q == GAP_LAST);
            default: issue_slot = 1'b0;
        endcase

        // A record in SEND has not been counted yet; include it so the
        // outstanding limit can never be exceeded.
        outst_eff = {1'b0, outst_q} + {4'b0, send_now};
        issue     = issue_slot && !empty_q && cif.ready && (outst_eff < MAX_O);
        push_ok   = push && (!full_q || issue);

        case (state_q)
            S_IDLE: begin
                if (issue) state_d = S_SEND;
            end
            S_SEND: begin
                if (GAP == 0) begin
                    state_d = issue ? S_SEND : S_IDLE;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = 3'd0;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = issue ? S_SEND : S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            in_valid_d = 1'b1;
            rec_d      = mem[rd_ptr_q[PW-1:0]];
        end

        if (push_ok) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (issue)   rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                  (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);

        if (push && !push_ok) overflow_d = 1'b1;

        // Issue and answer in the same cycle cancel; answers never underflow.
        if (send_now && !cif.out_valid) begin
            outst_d = outst_q + 4'd1;
        end else if (!send_now && cif.out_valid && (outst_q != 4'd0)) begin
            outst_d = outst_q - 4'd1;
        end
        if (cif.out_valid && (outst_q == 4'd0)) resp_err_d = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gap_cnt_q   <= 3'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            in_valid_q  <= 1'b0;
            rec_q       <= '0;
            outst_q     <= 4'd0;
            resp_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            in_valid_q  <= in_valid_d;
            rec_q       <= rec_d;
            outst_q     <= outst_d;
            resp_err_q  <= resp_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Record storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk1) begin
        if (rst_n && push_ok) mem[wr_ptr_q[PW-1:0]] <= push_data;
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign overflow    = overflow_q;
    assign outstanding = outst_q;
    assign resp_err    = resp_err_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;

    assign cif.in_valid    = in_valid_q;
    assign cif.doraemon_id = rec_q[37:33];
    assign cif.size        = rec_q[32:25];
    assign cif.iq_score    = rec_q[24:17];
    assign cif.eq_score    = rec_q[16:9];
    assign cif.size_weight = rec_q[8:6];
    assign cif.iq_weight   = rec_q[5:3];
    assign cif.eq_weight   = rec_q[2:0];
endmodule
